// File: rtl/pulse_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : pulse_arb_pkg
// Brief    : Shared types and helpers for the pulse event arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pulse_arb_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_POSEDGE = 2'b01,
        MODE_NEGEDGE = 2'b10,
        MODE_PULSE   = 2'b11
    } mode_e;

    // Channel index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin search starting one above the pointer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import pulse_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic          grant_valid,
    output logic [IW-1:0] grant_index
);

    // Walk from the farthest candidate down so the nearest one above ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_index = '0;
        for (int k = N; k >= 1; k--) begin
            if (en && req[(int'(ptr) + k) % N]) begin
                grant_valid = 1'b1;
                grant_index = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pulse_event_arbiter.sv
//------------------------------------------------------------------------------
// Module   : pulse_event_arbiter
// Brief    : Per-channel edge/pulse detection, one pending event per channel,
//            round-robin shared output. PULSE_ARB_TIMESTAMP_EN adds ev_ts.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_event_arbiter
    import pulse_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int TS_W = 16,
    localparam int IW   = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    a,
    input  logic [2*N-1:0]  mode,
    input  logic [N-1:0]    ovf_clr,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [IW-1:0]   ev_chan,
    output logic [1:0]      ev_kind,
    output logic [N-1:0]    ovf
`ifdef PULSE_ARB_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0] ev_ts
`endif
);

    if (N < 2 || N > 16 || TS_W < 1) begin : g_param_check
        $error("pulse_event_arbiter: unsupported N or TS_W");
    end

    logic [N-1:0]  r_a1;
    logic [N-1:0]  r_a2;
    logic [N-1:0]  r_pend;
    logic [1:0]    r_kind [N];
    logic [IW-1:0] r_ptr;

    logic [N-1:0]  w_det;
    logic [N-1:0]  w_gnt;
    logic [N-1:0]  w_cap;
    logic [N-1:0]  w_ovf_set;
    logic          w_load;
    logic          w_gv;
    logic [IW-1:0] w_gi;

    always_comb begin
        w_det = '0;
        for (int i = 0; i < N; i++) begin
            case (mode_e'(mode[2*i +: 2]))
                MODE_POSEDGE: w_det[i] = a[i] & ~r_a1[i];
                MODE_NEGEDGE: w_det[i] = ~a[i] & r_a1[i];
                MODE_PULSE:   w_det[i] = ~a[i] & r_a1[i] & ~r_a2[i];
                default:      w_det[i] = 1'b0;
            endcase
        end
    end

    assign w_load = ~ev_valid | ev_ready;

    rr_arbiter #(.N(N)) u_rr (
        .req         (r_pend),
        .ptr         (r_ptr),
        .en          (w_load),
        .grant_valid (w_gv),
        .grant_index (w_gi)
    );

    always_comb begin
        w_gnt = '0;
        if (w_gv) begin
            w_gnt[w_gi] = 1'b1;
        end
    end

    // A detection on a channel being granted this cycle re-arms it instead of overflowing.
    assign w_cap     = w_det & (~r_pend | w_gnt);
    assign w_ovf_set = w_det & r_pend & ~w_gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a1     <= '0;
            r_a2     <= '0;
            r_pend   <= '0;
            ovf      <= '0;
            ev_valid <= 1'b0;
            ev_chan  <= '0;
            ev_kind  <= 2'b00;
            r_ptr    <= IW'(N - 1);
            for (int i = 0; i < N; i++) begin
                r_kind[i] <= 2'b00;
            end
        end else begin
            r_a1   <= a;
            r_a2   <= r_a1;
            r_pend <= w_det | (r_pend & ~w_gnt);
            ovf    <= w_ovf_set | (ovf & ~ovf_clr);
            for (int i = 0; i < N; i++) begin
                if (w_cap[i]) begin
                    r_kind[i] <= mode[2*i +: 2];
                end
            end
            if (w_load) begin
                ev_valid <= w_gv;
                if (w_gv) begin
                    ev_chan <= w_gi;
                    ev_kind <= r_kind[w_gi];
                    r_ptr   <= w_gi;
                end
            end
        end
    end

`ifdef PULSE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts_cap [N];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ts_cnt <= '0;
            ev_ts    <= '0;
            for (int i = 0; i < N; i++) begin
                r_ts_cap[i] <= '0;
            end
        end else begin
            r_ts_cnt <= r_ts_cnt + TS_W'(1);
            for (int i = 0; i < N; i++) begin
                if (w_cap[i]) begin
                    r_ts_cap[i] <= r_ts_cnt;
                end
            end
            if (w_load && w_gv) begin
                ev_ts <= r_ts_cap[w_gi];
            end
        end
    end
`endif

endmodule

`default_nettype wire
